// File: rtl/alu_seq_core.sv
// alu_seq_core: single-clock ALU datapath core.
//   Operand registers A/B loaded from `sw`, a registered result/flag pair,
//   and a WIDTH-cycle shift-add multiplier behind a go/busy/done handshake.
// Ports:
//   clk     system clock, all state changes on the rising edge
//   rst_n   synchronous active-low reset
//   sw      operand input bus
//   ld_a    strobe: load sw into A (honoured in IDLE/DONE only)
//   ld_b    strobe: load sw into B (honoured in IDLE/DONE only)
//   op      operation code, sampled together with go
//   go      strobe: start an operation
//   result  registered result
//   F       registered flags {ZF, CF, OF, SF}
//   busy    high while an operation is in progress
//   done    one-cycle pulse in the cycle after result/F update
module alu_seq_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [3:0]       op,
  input  logic             go,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       F,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, wa_q, wb_q, result_q;
  logic [3:0]         op_q, f_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;

  logic [WIDTH:0]     add_w, sub_w;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf, alu_of;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   result_d;
  logic               cf_d, of_d;
  logic [3:0]         f_d;
  logic               idle_like;

  // Combinational ALU on the snapshot operands
  always_comb begin
    shamt   = wb_q[SHW-1:0];
    add_w   = {1'b0, wa_q} + {1'b0, wb_q};
    sub_w   = {1'b0, wa_q} - {1'b0, wb_q};
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (op_q)
      4'd0: alu_res = wa_q & wb_q;
      4'd1: alu_res = wa_q | wb_q;
      4'd2: alu_res = wa_q ^ wb_q;
      4'd3: alu_res = ~(wa_q | wb_q);
      4'd4: begin
        alu_res = add_w[WIDTH-1:0];
        alu_cf  = add_w[WIDTH];
        alu_of  = (wa_q[WIDTH-1] == wb_q[WIDTH-1]) &&
                  (add_w[WIDTH-1] != wa_q[WIDTH-1]);
      end
      4'd5: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_cf  = sub_w[WIDTH];  // borrow out == (A < B) unsigned
        alu_of  = (wa_q[WIDTH-1] != wb_q[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != wa_q[WIDTH-1]);
      end
      4'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(wa_q) < $signed(wb_q))};
      4'd7: alu_res = wa_q << shamt;
      4'd8: alu_res = wa_q >> shamt;
      4'd9: alu_res = WIDTH'($signed(wa_q) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per cycle; prod_d already includes the current bit,
  // so on the last iteration it is the full product.
  always_comb begin
    prod_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == MUL) begin
      result_d = prod_d[WIDTH-1:0];
      cf_d     = |prod_d[2*WIDTH-1:WIDTH];
      of_d     = |prod_d[2*WIDTH-1:WIDTH];
    end else begin
      result_d = alu_res;
      cf_d     = alu_cf;
      of_d     = alu_of;
    end
    f_d       = {(result_d == '0), cf_d, of_d, result_d[WIDTH-1]};
    idle_like = (state_q == IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      op_q     <= '0;
      result_q <= '0;
      f_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (idle_like) begin
        if (ld_a) a_q <= sw;
        if (ld_b) b_q <= sw;
      end
      case (state_q)
        // DONE lasts one cycle and then behaves exactly like IDLE, so a go
        // presented during the done pulse is taken (back-to-back ops).
        IDLE, DONE: begin
          if (go) begin
            wa_q     <= a_q;
            wb_q     <= b_q;
            op_q     <= op;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_q};
            mplier_q <= b_q;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= (op == 4'd10) ? MUL : EXEC;
          end else begin
            state_q  <= IDLE;
          end
        end
        EXEC: begin
          result_q <= result_d;
          f_q      <= f_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        MUL: begin
          if (cnt_q == SHW'(WIDTH - 1)) begin
            result_q <= result_d;
            f_q      <= f_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            acc_q    <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign F      = f_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
